// File: rtl/spgd_dac_pkg.sv
// Shared definitions for the SPGD actuator DAC path.
// Contents: the writer FSM state type, the DAC write-and-update command code
// and the default frame geometry used by dac_spi_writer.
package spgd_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_GAP      = 3'd4
    } dac_state_e;

    localparam logic [3:0]  DAC_CMD_WRITE_UPDATE = 4'b0011;

    localparam int unsigned DEFAULT_WIRE_WIDTH = 12;
    localparam int unsigned DEFAULT_CMD_BITS   = 4;
    localparam int unsigned DEFAULT_FRAME_BITS = 16;
    localparam int unsigned DEFAULT_CLK_DIV    = 4;

endpackage

// File: rtl/spi_bit_timer.sv
// SPI timing for dac_spi_writer: CLK_DIV-cycle phase counter plus bit counter.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   run          - frame in progress (counter held at 0 otherwise)
//   shift_en     - data bits are being shifted (sclk toggling)
//   tick_c       - last cycle of the current CLK_DIV-long phase
//   rise_c       - end of an sclk-low phase while shifting (sclk should rise)
//   fall_c       - end of an sclk-high phase while shifting (sclk should fall)
//   last_bit_c   - the bit on the wire is bit FRAME_BITS-1
module spi_bit_timer #(
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic shift_en,
    output logic tick_c,
    output logic rise_c,
    output logic fall_c,
    output logic last_bit_c
);

    localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);

    logic [PH_W-1:0]  ph_q, ph_d;
    logic             hi_q, hi_d;
    logic [BIT_W-1:0] bit_q, bit_d;

    // Strobes; phases follow each other back to back so the counter never needs re-alignment.
    always_comb begin
        tick_c     = run && (ph_q == PH_W'(CLK_DIV - 1));
        rise_c     = tick_c && shift_en && !hi_q;
        fall_c     = tick_c && shift_en && hi_q;
        last_bit_c = (bit_q == BIT_W'(FRAME_BITS - 1));
    end

    // Next-state for phase, sclk-half and bit counters.
    always_comb begin
        ph_d  = ph_q;
        hi_d  = hi_q;
        bit_d = bit_q;
        if (!run || tick_c) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + PH_W'(1);
        end
        if (!shift_en) begin
            hi_d  = 1'b0;
            bit_d = '0;
        end else begin
            if (tick_c) begin
                hi_d = !hi_q;
            end
            if (fall_c) begin
                bit_d = bit_q + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q  <= '0;
            hi_q  <= 1'b0;
            bit_q <= '0;
        end else begin
            ph_q  <= ph_d;
            hi_q  <= hi_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/dac_spi_writer.sv
// Serialises offset-binary DAC codes into SPI frames {DAC_CMD, data, zero pad}, MSB first.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   data_in     - offset-binary DAC code
//   data_valid  - data_in valid this cycle; taken when ready is also high
//   ready       - a word can be accepted this cycle
//   sclk        - SPI clock, idles low, DAC samples on its rising edge
//   sdi         - SPI data, changes on sclk falling edges
//   cs_n        - DAC chip select, active low
//   done        - one-cycle pulse after cs_n rises at frame end
// Build option: define DAC_SKID_BUF_EN to add a one-word holding register so a
// word can be accepted mid-frame and sent right after the inter-frame gap.
module dac_spi_writer
    import spgd_dac_pkg::*;
#(
    parameter int unsigned          WIRE_WIDTH = DEFAULT_WIRE_WIDTH,
    parameter int unsigned          CMD_BITS   = DEFAULT_CMD_BITS,
    parameter int unsigned          FRAME_BITS = DEFAULT_FRAME_BITS,
    parameter logic [CMD_BITS-1:0]  DAC_CMD    = CMD_BITS'(DAC_CMD_WRITE_UPDATE),
    parameter int unsigned          CLK_DIV    = DEFAULT_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIRE_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  ready,
    output logic                  sclk,
    output logic                  sdi,
    output logic                  cs_n,
    output logic                  done
);

    localparam int unsigned PAD_BITS = FRAME_BITS - CMD_BITS - WIRE_WIDTH;

    dac_state_e            state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  ready_q, ready_d;
    logic                  sclk_q, sclk_d;
    logic                  sdi_q, sdi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  done_q, done_d;

    logic                  accept_c;
    logic                  start_c;
    logic [WIRE_WIDTH-1:0] start_word_c;
    logic [FRAME_BITS-1:0] start_frame_c;
    logic                  tick_c, rise_c, fall_c, last_bit_c;

`ifdef DAC_SKID_BUF_EN
    logic [WIRE_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;
`endif

    spi_bit_timer #(
        .FRAME_BITS (FRAME_BITS),
        .CLK_DIV    (CLK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (state_q != ST_IDLE),
        .shift_en   (state_q == ST_SHIFT),
        .tick_c     (tick_c),
        .rise_c     (rise_c),
        .fall_c     (fall_c),
        .last_bit_c (last_bit_c)
    );

    // Word that opens the next frame; a held word only exists while a frame is running.
    always_comb begin
        accept_c     = data_valid && ready_q;
`ifdef DAC_SKID_BUF_EN
        start_word_c = hold_vld_q ? hold_q : data_in;
`else
        start_word_c = data_in;
`endif
        start_frame_c = FRAME_BITS'({DAC_CMD, start_word_c}) << PAD_BITS;
    end

    // Frame sequencing: next state and registered outputs.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        sdi_d   = sdi_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;
        ready_d = 1'b0;
        start_c = 1'b0;
`ifdef DAC_SKID_BUF_EN
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cs_n_d  = 1'b1;
                start_c = accept_c;
            end
            ST_CS_SETUP: begin
                if (tick_c) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_c) begin
                    sclk_d = 1'b1;
                end
                if (fall_c) begin
                    sclk_d = 1'b0;
                    if (last_bit_c) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        sdi_d   = shreg_q[FRAME_BITS-1];
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (tick_c) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    sdi_d   = 1'b0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick_c) begin
`ifdef DAC_SKID_BUF_EN
                    if (hold_vld_q) begin
                        start_c    = 1'b1;
                        hold_vld_d = 1'b0;
                    end else if (accept_c) begin
                        start_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef DAC_SKID_BUF_EN
        // A word taken while a frame is running waits in the holding register.
        if (accept_c && !start_c) begin
            hold_d     = data_in;
            hold_vld_d = 1'b1;
        end
`endif

        if (start_c) begin
            state_d = ST_CS_SETUP;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            sdi_d   = start_frame_c[FRAME_BITS-1];
            shreg_d = start_frame_c << 1;
        end

`ifdef DAC_SKID_BUF_EN
        ready_d = !hold_vld_d;
`else
        ready_d = (state_d == ST_IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            ready_q <= 1'b0;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            sclk_q  <= sclk_d;
            sdi_q   <= sdi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
        end
    end

`ifdef DAC_SKID_BUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    assign ready = ready_q;
    assign sclk  = sclk_q;
    assign sdi   = sdi_q;
    assign cs_n  = cs_n_q;
    assign done  = done_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Self-checking bench for dac_spi_writer: dut_a uses default parameters,
// dut_b uses CLK_DIV=1. Expected frames and timings come from the frame
// layout {cmd, data, pad} and the 2*CLK_DIV*(FRAME_BITS+1) frame length.
module tb_dac_spi_writer;

    localparam int unsigned W  = 12;
    localparam int unsigned FB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [W-1:0] a_data = '0;
    logic [W-1:0] b_data = '0;
    logic a_valid = 1'b0;
    logic b_valid = 1'b0;
    logic a_ready, a_sclk, a_sdi, a_cs_n, a_done;
    logic b_ready, b_sclk, b_sdi, b_cs_n, b_done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dac_spi_writer dut_a (
        .clk(clk), .rst(rst), .data_in(a_data), .data_valid(a_valid),
        .ready(a_ready), .sclk(a_sclk), .sdi(a_sdi), .cs_n(a_cs_n), .done(a_done)
    );

    dac_spi_writer #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .data_in(b_data), .data_valid(b_valid),
        .ready(b_ready), .sclk(b_sclk), .sdi(b_sdi), .cs_n(b_cs_n), .done(b_done)
    );

    // Reference frame: command 0x3 in the top 4 bits, then the word, then zeros.
    function automatic logic [FB-1:0] model_frame(input logic [W-1:0] d);
        int unsigned v;
        v = (32'h3 << (FB - 4)) | (32'(d) << (FB - 4 - W));
        return FB'(v);
    endfunction

    function automatic int frame_cycles(input int div);
        return 2 * div * (FB + 1);
    endfunction

    task automatic send(input bit which, input logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while ((which ? b_ready : a_ready) !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            $display("FAIL send_ready: ready=%b, required 1", which ? b_ready : a_ready);
        end
        if (which) begin b_data = d; b_valid = 1'b1; end
        else       begin a_data = d; a_valid = 1'b1; end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Watches one frame starting just after the accept edge; ends when cs_n is back high and ready=1.
    task automatic observe(input bit which, input bit churn, output logic [FB-1:0] bits,
                           output int nrise, output int cs_low, output int cs_rise_at,
                           output int ndone, output int ready_at, output int unstable);
        logic ps, pd, sclk_s, sdi_s, cs_s, done_s, rdy_s;
        bit   seen_low;
        bits = '0; nrise = 0; cs_low = 0; cs_rise_at = -1; ndone = 0;
        ready_at = -1; unstable = 0; seen_low = 0;
        ps = which ? b_sclk : a_sclk;
        pd = which ? b_sdi  : a_sdi;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            sclk_s = which ? b_sclk  : a_sclk;
            sdi_s  = which ? b_sdi   : a_sdi;
            cs_s   = which ? b_cs_n  : a_cs_n;
            done_s = which ? b_done  : a_done;
            rdy_s  = which ? b_ready : a_ready;
            if (!ps && sclk_s) begin
                bits = {bits[FB-2:0], sdi_s};
                nrise++;
                if (sdi_s !== pd) unstable++;
            end
            if (cs_s === 1'b0) begin
                cs_low++;
                seen_low = 1;
            end else if (seen_low && cs_rise_at < 0) begin
                cs_rise_at = i - 1;
            end
            if (done_s === 1'b1) ndone++;
            if (seen_low && cs_s === 1'b1 && rdy_s === 1'b1) begin
                ready_at = i - 1;
                break;
            end
            if (churn) begin
                a_valid = 1'b1;
                a_data  = W'($urandom);
            end
            ps = sclk_s;
            pd = sdi_s;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({a_ready, a_sclk, a_sdi, a_cs_n, a_done} !== 5'b00010) begin
            $display("FAIL reset_outputs: ready/sclk/sdi/cs_n/done=%b, required 00010",
                     {a_ready, a_sclk, a_sdi, a_cs_n, a_done});
        end else passed++;
        total++;
        if ({b_ready, b_cs_n} !== 2'b01) begin
            $display("FAIL reset_outputs_b: ready/cs_n=%b, required 01", {b_ready, b_cs_n});
        end else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1) begin
            $display("FAIL ready_after_reset: ready=%b, required 1", a_ready);
        end else passed++;
    endtask

    task automatic test_basic;
        logic [FB-1:0] bits, exp;
        int nr, csl, csr, nd, rdy, uns;
        send(0, 12'h8A3);
        observe(0, 0, bits, nr, csl, csr, nd, rdy, uns);
        exp = model_frame(12'h8A3);
        total++;
        if (bits !== exp) $display("FAIL basic_bits: got %h, required %h", bits, exp); else passed++;
        total++;
        if (nr != FB) $display("FAIL basic_rises: got %0d, required %0d", nr, FB); else passed++;
        total++;
        if (csl != frame_cycles(4)) $display("FAIL basic_cs_low: got %0d, required %0d", csl, frame_cycles(4)); else passed++;
        total++;
        if (csr != frame_cycles(4)) $display("FAIL basic_cs_rise: got %0d, required %0d", csr, frame_cycles(4)); else passed++;
        total++;
        if (nd != 1) $display("FAIL basic_done: got %0d pulses, required 1", nd); else passed++;
`ifndef DAC_SKID_BUF_EN
        total++;
        if (rdy != frame_cycles(4) + 4) $display("FAIL basic_ready: got %0d, required %0d", rdy, frame_cycles(4) + 4); else passed++;
`endif
        total++;
        if (uns != 0) $display("FAIL basic_sdi_stable: got %0d changes, required 0", uns); else passed++;
    endtask

    task automatic test_full_zero;
        logic [W-1:0]  words [2];
        logic [FB-1:0] bits, exp;
        int nr, csl, csr, nd, rdy, uns;
        words[0] = 12'hFFF;
        words[1] = 12'h000;
        for (int j = 0; j < 2; j++) begin
            send(0, words[j]);
            observe(0, 0, bits, nr, csl, csr, nd, rdy, uns);
            exp = model_frame(words[j]);
            total++;
            if (bits !== exp) $display("FAIL fullzero_bits: got %h, required %h", bits, exp); else passed++;
            total++;
            if (uns != 0 || nr != FB) $display("FAIL fullzero_stable: changes=%0d rises=%0d, required 0 and %0d", uns, nr, FB); else passed++;
        end
    endtask

    task automatic test_random;
        logic [W-1:0]  w;
        logic [FB-1:0] bits, exp;
        int nr, csl, csr, nd, rdy, uns;
        for (int j = 0; j < 4; j++) begin
            w = W'($urandom);
            send(0, w);
            observe(0, 0, bits, nr, csl, csr, nd, rdy, uns);
            exp = model_frame(w);
            total++;
            if (bits !== exp) $display("FAIL random_bits: word %h got %h, required %h", w, bits, exp); else passed++;
            total++;
            if (nd != 1) $display("FAIL random_done: got %0d pulses, required 1", nd); else passed++;
        end
    endtask

`ifndef DAC_SKID_BUF_EN
    task automatic test_ignored;
        logic [W-1:0]  nxt;
        logic [FB-1:0] bits, exp;
        int nr, csl, csr, nd, rdy, uns;
        send(0, 12'h5C6);
        observe(0, 1, bits, nr, csl, csr, nd, rdy, uns);
        exp = model_frame(12'h5C6);
        total++;
        if (bits !== exp) $display("FAIL ignored_first: got %h, required %h", bits, exp); else passed++;
        total++;
        if (nd != 1) $display("FAIL ignored_done: got %0d pulses, required 1", nd); else passed++;
        total++;
        if (rdy != frame_cycles(4) + 4) $display("FAIL ignored_ready: got %0d, required %0d", rdy, frame_cycles(4) + 4); else passed++;
        nxt = a_data;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        observe(0, 0, bits, nr, csl, csr, nd, rdy, uns);
        exp = model_frame(nxt);
        total++;
        if (bits !== exp || csr != frame_cycles(4)) $display("FAIL ignored_next: got %h/%0d, required %h/%0d", bits, csr, exp, frame_cycles(4)); else passed++;
    endtask
`endif

    task automatic test_reset_mid;
        logic [7:0]    got;
        logic [FB-1:0] mf, bits, exp;
        logic          prev;
        int nr, nd, csl, csr, rdy, uns;
        send(0, 12'h0A10);
        got = '0; nr = 0; prev = a_sclk;
        for (int i = 0; i < 200 && nr < 8; i++) begin
            @(negedge clk);
            if (!prev && a_sclk) begin
                got = {got[6:0], a_sdi};
                nr++;
            end
            prev = a_sclk;
        end
        mf = model_frame(12'h0A10);
        total++;
        if (got !== mf[FB-1:FB-8]) $display("FAIL midrst_prefix: got %h, required %h", got, mf[FB-1:FB-8]); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({a_cs_n, a_sclk, a_done} !== 3'b100) $display("FAIL midrst_abort: cs_n/sclk/done=%b, required 100", {a_cs_n, a_sclk, a_done}); else passed++;
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_done === 1'b1 || a_cs_n !== 1'b1) nd++;
        end
        total++;
        if (nd != 0) $display("FAIL midrst_quiet: got %0d bad cycles, required 0", nd); else passed++;
        total++;
        if (a_ready !== 1'b1) $display("FAIL midrst_ready: ready=%b, required 1", a_ready); else passed++;
        send(0, 12'h7FF);
        observe(0, 0, bits, nr, csl, csr, nd, rdy, uns);
        exp = model_frame(12'h7FF);
        total++;
        if (bits !== exp) $display("FAIL midrst_next: got %h, required %h", bits, exp); else passed++;
        total++;
        if (csr != frame_cycles(4) || nd != 1) $display("FAIL midrst_next_len: cs_rise=%0d done=%0d, required %0d and 1", csr, nd, frame_cycles(4)); else passed++;
    endtask

    task automatic test_clk_div1;
        logic [FB-1:0] bits, exp;
        int nr, csl, csr, nd, rdy, uns;
        send(1, 12'h9B2);
        observe(1, 0, bits, nr, csl, csr, nd, rdy, uns);
        exp = model_frame(12'h9B2);
        total++;
        if (bits !== exp) $display("FAIL div1_bits: got %h, required %h", bits, exp); else passed++;
        total++;
        if (csr != frame_cycles(1)) $display("FAIL div1_len: got %0d, required %0d", csr, frame_cycles(1)); else passed++;
        total++;
        if (nr != FB || uns != 0) $display("FAIL div1_rises: rises=%0d changes=%0d, required %0d and 0", nr, uns, FB); else passed++;
`ifndef DAC_SKID_BUF_EN
        total++;
        if (rdy != frame_cycles(1) + 1) $display("FAIL div1_ready: got %0d, required %0d", rdy, frame_cycles(1) + 1); else passed++;
`endif
    endtask

`ifdef DAC_SKID_BUF_EN
    task automatic test_skid;
        logic [2*FB-1:0] bits, exp;
        logic [FB-1:0]   f0, f1;
        logic            ps, pc;
        int nr, nd, gap, ncs;
        bits = '0; nr = 0; nd = 0; gap = 0; ncs = 0;
        repeat (8) @(negedge clk);
        send(0, 12'h001);
        ps = a_sclk; pc = a_cs_n;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (!ps && a_sclk) begin
                bits = {bits[2*FB-2:0], a_sdi};
                nr++;
            end
            if (a_done === 1'b1) nd++;
            if (pc === 1'b0 && a_cs_n === 1'b1) ncs++;
            if (ncs == 1 && a_cs_n === 1'b1) gap++;
            ps = a_sclk; pc = a_cs_n;
            if (ncs == 2) break;
            if (i == 20) begin a_data = 12'hCA3; a_valid = 1'b1; end
            if (i == 21) a_valid = 1'b0;
        end
        f0 = model_frame(12'h001);
        f1 = model_frame(12'hCA3);
        exp = {f0, f1};
        total++;
        if (bits !== exp || nr != 2 * FB) $display("FAIL skid_bits: got %h (%0d rises), required %h", bits, nr, exp); else passed++;
        total++;
        if (gap != 4) $display("FAIL skid_gap: cs_n high %0d cycles, required 4", gap); else passed++;
        total++;
        if (nd != 2) $display("FAIL skid_done: got %0d pulses, required 2", nd); else passed++;
    endtask
`endif

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_full_zero();
        test_random();
`ifndef DAC_SKID_BUF_EN
        test_ignored();
`endif
        test_reset_mid();
        test_clk_div1();
`ifdef DAC_SKID_BUF_EN
        test_skid();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
